// File: rtl/mc_sequencer_if.sv
// Instruction and data bus bundle for mc_sequencer.
// master: sequencer side (drives requests); slave: memory side (drives responses).
interface mc_sequencer_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [ILEN-1:0] iresp_data;

  logic              dreq_valid;
  logic [XLEN-1:0]   dreq_addr;
  logic [XLEN/8-1:0] dreq_strobe;
  logic [XLEN-1:0]   dreq_data;
  logic              dresp_data_ok;
  logic [XLEN-1:0]   dresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data,
    output dreq_valid,
    output dreq_addr,
    output dreq_strobe,
    output dreq_data,
    input  dresp_data_ok,
    input  dresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data,
    input  dreq_valid,
    input  dreq_addr,
    input  dreq_strobe,
    input  dreq_data,
    output dresp_data_ok,
    output dresp_data
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: IFETCH -> DECODE -> EXECUTE -> [MEM] -> WB.
// Ports: clk, rst (sync, active-high); bus (mc_sequencer_if.master) for
// instruction/data requests; dec_* / ex_* / next_pc from decode/execute;
// pc, instr, mem_rdata, rf_we, commit_valid, commit_pc outputs.
// Optional SEQ_PERF_CNT_EN adds 64-bit mcycle / minstret counters.
module mc_sequencer #(
  parameter int XLEN      = 64,
  parameter int ILEN      = 32,
  parameter int MULTI_LAT = 4,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  mc_sequencer_if.master    bus,
  input  logic              dec_mem_rd,
  input  logic              dec_mem_wr,
  input  logic              dec_multi,
  input  logic              dec_rf_we,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [XLEN/8-1:0] ex_strobe,
  input  logic [XLEN-1:0]   next_pc,
  output logic [XLEN-1:0]   pc,
  output logic [ILEN-1:0]   instr,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              rf_we,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [63:0]       mcycle,
  output logic [63:0]       minstret
`endif
);

  localparam logic [2:0] S_IFETCH  = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;

  localparam logic [3:0] CNT_MULTI = 4'(MULTI_LAT - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic       ld_q;
  logic       mem_op;
  logic       is_load;

  assign mem_op  = dec_mem_rd | dec_mem_wr;
  // a simultaneous rd+wr is treated as a load
  assign is_load = dec_mem_rd;

  // request address follows pc, which only changes when leaving WB
  assign bus.ireq_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IFETCH;
      pc              <= RESET_PC;
      instr           <= '0;
      mem_rdata       <= '0;
      cnt             <= '0;
      ld_q            <= 1'b0;
      bus.ireq_valid  <= 1'b0;
      bus.dreq_valid  <= 1'b0;
      bus.dreq_strobe <= '0;
      bus.dreq_addr   <= '0;
      bus.dreq_data   <= '0;
      rf_we           <= 1'b0;
      commit_valid    <= 1'b0;
      commit_pc       <= '0;
    end else begin
      rf_we        <= 1'b0;
      commit_valid <= 1'b0;
      unique case (state)
        S_IFETCH: begin
          // request is idle only in the first cycle after reset
          if (!bus.ireq_valid) begin
            bus.ireq_valid <= 1'b1;
          end else if (bus.iresp_data_ok) begin
            instr          <= bus.iresp_data;
            bus.ireq_valid <= 1'b0;
            state          <= S_DECODE;
          end
        end
        S_DECODE: begin
          cnt   <= dec_multi ? CNT_MULTI : 4'd0;
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (mem_op) begin
            ld_q            <= is_load;
            bus.dreq_valid  <= 1'b1;
            bus.dreq_addr   <= ex_addr;
            bus.dreq_data   <= ex_wdata;
            bus.dreq_strobe <= is_load ? '0 : ex_strobe;
            state           <= S_MEM;
          end else begin
            commit_valid <= 1'b1;
            commit_pc    <= pc;
            rf_we        <= dec_rf_we;
            state        <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dresp_data_ok) begin
            if (ld_q) begin
              mem_rdata <= bus.dresp_data;
            end
            bus.dreq_valid  <= 1'b0;
            bus.dreq_strobe <= '0;
            commit_valid    <= 1'b1;
            commit_pc       <= pc;
            rf_we           <= dec_rf_we;
            state           <= S_WB;
          end
        end
        S_WB: begin
          // issue the next fetch right away for a zero-gap refetch
          pc             <= next_pc;
          bus.ireq_valid <= 1'b1;
          state          <= S_IFETCH;
        end
        default: begin
          state <= S_IFETCH;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (commit_valid) begin
        minstret <= minstret + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Testbench for mc_sequencer: directed scenarios then random instructions
// against a cycle-count reference model.
module tb_mc_sequencer;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int MLAT = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        dec_mem_rd = 0;
  logic        dec_mem_wr = 0;
  logic        dec_multi = 0;
  logic        dec_rf_we = 0;
  logic [63:0] ex_addr = 0;
  logic [63:0] ex_wdata = 0;
  logic [7:0]  ex_strobe = 0;
  logic [63:0] next_pc = 0;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [63:0] mem_rdata;
  logic        rf_we;
  logic        commit_valid;
  logic [63:0] commit_pc;
`ifdef SEQ_PERF_CNT_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;
`endif

  mc_sequencer_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  mc_sequencer #(
    .XLEN(XLEN),
    .ILEN(ILEN),
    .MULTI_LAT(MLAT),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dec_mem_rd(dec_mem_rd),
    .dec_mem_wr(dec_mem_wr),
    .dec_multi(dec_multi),
    .dec_rf_we(dec_rf_we),
    .ex_addr(ex_addr),
    .ex_wdata(ex_wdata),
    .ex_strobe(ex_strobe),
    .next_pc(next_pc),
    .pc(pc),
    .instr(instr),
    .mem_rdata(mem_rdata),
    .rf_we(rf_we),
    .commit_valid(commit_valid),
    .commit_pc(commit_pc)
`ifdef SEQ_PERF_CNT_EN
    ,
    .mcycle(mcycle),
    .minstret(minstret)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_rdata;
  logic [63:0] m_cyc;
  logic [63:0] m_ret;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.iresp_data_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk1("rst_ireq_valid", bus.ireq_valid, 1'b0);
    chk1("rst_dreq_valid", bus.dreq_valid, 1'b0);
    chk("rst_strobe", 64'(bus.dreq_strobe), 64'd0);
    chk1("rst_commit", commit_valid, 1'b0);
    chk1("rst_rf_we", rf_we, 1'b0);
    chk("rst_commit_pc", commit_pc, 64'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_ireq_addr", bus.ireq_addr, RPC);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_mem_rdata", mem_rdata, 64'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("rst_mcycle", mcycle, 64'd0);
    chk("rst_minstret", minstret, 64'd0);
`endif
    rst = 1'b0;
    m_pc = RPC;
    m_instr = '0;
    m_rdata = '0;
    m_cyc = '0;
    m_ret = '0;
  endtask

  // One instruction: cycle c=1 is the first cycle with a fetch request.
  task automatic run_instr(input string tag,
                           input bit rd, input bit wr,
                           input bit multi, input bit rfw,
                           input int fw, input int mw,
                           input logic [63:0] addr,
                           input logic [63:0] wdata,
                           input logic [7:0] strb,
                           input logic [63:0] rdata,
                           input logic [63:0] npc,
                           input int abort_at);
    bit mem;
    int nf, ne, nm, total, ex_end, mem_end;
    logic [7:0] exp_strb;
    mem = rd | wr;
    nf = fw + 1;
    ne = multi ? MLAT : 1;
    nm = mem ? mw + 1 : 0;
    ex_end = nf + 1 + ne;
    mem_end = ex_end + nm;
    total = mem_end + 1;
    exp_strb = rd ? 8'h00 : strb;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk);
      #1;
      m_cyc++;
      if (c == 1) begin
        dec_mem_rd = rd;
        dec_mem_wr = wr;
        dec_multi = multi;
        dec_rf_we = rfw;
        ex_addr = addr;
        ex_wdata = wdata;
        ex_strobe = strb;
        next_pc = npc;
      end
      chk1({tag, "_ireq_valid"}, bus.ireq_valid, c <= nf);
      chk1({tag, "_dreq_valid"}, bus.dreq_valid,
           c > ex_end && c <= mem_end);
      chk1({tag, "_excl"}, bus.ireq_valid & bus.dreq_valid, 1'b0);
      chk1({tag, "_commit"}, commit_valid, c == total);
      chk1({tag, "_rf_we"}, rf_we, c == total && rfw);
      chk({tag, "_pc"}, pc, m_pc);
      if (c <= nf) begin
        chk({tag, "_ireq_addr"}, bus.ireq_addr, m_pc);
      end
      if (c > ex_end && c <= mem_end) begin
        chk({tag, "_dreq_addr"}, bus.dreq_addr, addr);
        chk({tag, "_dreq_data"}, bus.dreq_data, wdata);
        chk({tag, "_dreq_strobe"}, 64'(bus.dreq_strobe), 64'(exp_strb));
      end
      if (c == total) begin
        chk({tag, "_commit_pc"}, commit_pc, m_pc);
        chk({tag, "_instr"}, 64'(instr), 64'(m_instr));
        chk({tag, "_mem_rdata"}, mem_rdata, m_rdata);
`ifdef SEQ_PERF_CNT_EN
        chk({tag, "_mcycle"}, mcycle, m_cyc);
        chk({tag, "_minstret"}, minstret, m_ret);
`endif
      end
      if (c == abort_at) begin
        do_reset(1);
        return;
      end
      bus.iresp_data = $urandom;
      if (c <= nf) begin
        bus.iresp_data_ok = (c == nf);
      end else begin
        bus.iresp_data_ok = 1'($urandom % 2);
      end
      if (c == nf) begin
        m_instr = bus.iresp_data;
      end
      if (mem && c == mem_end) begin
        bus.dresp_data = rdata;
        bus.dresp_data_ok = 1'b1;
        if (rd) begin
          m_rdata = rdata;
        end
      end else if (c > ex_end && c <= mem_end) begin
        bus.dresp_data = {$urandom, $urandom};
        bus.dresp_data_ok = 1'b0;
      end else begin
        bus.dresp_data = {$urandom, $urandom};
        bus.dresp_data_ok = 1'($urandom % 2);
      end
    end
    m_pc = npc;
    m_ret++;
  endtask

  initial begin
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data = '0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data = '0;
    do_reset(3);

    run_instr("alu", 0, 0, 0, 1, 0, 0, 64'h0, 64'h0, 8'h00,
              64'h0, RPC + 64'd4, 0);
    run_instr("fwait", 0, 0, 0, 1, 3, 0, 64'h0, 64'h0, 8'h00,
              64'h0, 64'h8000_0100, 0);
    run_instr("load", 1, 0, 0, 1, 0, 2, 64'h1000, 64'h55, 8'hFF,
              64'hDEAD_BEEF, 64'h8000_0104, 0);
    run_instr("store", 0, 1, 0, 0, 1, 1, 64'h2000, 64'h1234, 8'h0F,
              64'h7777, 64'h8000_0108, 0);
    run_instr("multi", 0, 0, 1, 1, 0, 0, 64'h0, 64'h0, 8'h00,
              64'h0, 64'h8000_010C, 0);
    run_instr("rdwr", 1, 1, 0, 1, 0, 0, 64'h3000, 64'h99, 8'hF0,
              64'hCAFE_F00D, 64'h8000_0110, 0);
    run_instr("abort", 1, 0, 0, 1, 0, 5, 64'h4000, 64'h0, 8'h00,
              64'h1111, 64'h8000_0114, 5);
    run_instr("post", 0, 0, 0, 1, 0, 0, 64'h0, 64'h0, 8'h00,
              64'h0, RPC + 64'd4, 0);

    for (int i = 0; i < 40; i++) begin
      run_instr("rnd",
                1'($urandom % 2), 1'($urandom % 2),
                1'($urandom % 2), 1'($urandom % 2),
                int'($urandom % 4), int'($urandom % 4),
                {$urandom, $urandom}, {$urandom, $urandom},
                8'($urandom), {$urandom, $urandom},
                {$urandom, $urandom}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, meaning datapath/address width.
REQ-002 The module SHALL have parameter ILEN, default 32, meaning instruction width.
REQ-003 The module SHALL have parameter MULTI_LAT, default 4, range 1..15, meaning EXECUTE cycles for a multi-cycle op.
REQ-004 The module SHALL have parameter RESET_PC, default 64'h8000_0000, meaning first fetch address.
REQ-005 The module SHALL have port clk, input, 1 bit, meaning the single clock (all logic on posedge).
REQ-006 The module SHALL have port rst, input, 1 bit, meaning reset, which is synchronous and active-high.
REQ-007 The module SHALL have these instruction-bus ports:
- ireq_valid: output, 1 bit, fetch request.
- ireq_addr: output, XLEN bits, fetch address.
- iresp_data_ok: input, 1 bit, fetch data returned.
- iresp_data: input, ILEN bits, fetched instruction.
REQ-008 The module SHALL have these data-bus ports:
- dreq_valid: output, 1 bit, data request.
- dreq_addr: output, XLEN bits, data address.
- dreq_strobe: output, XLEN/8 bits, byte write enables; all zero means read.
- dreq_data: output, XLEN bits, store data.
- dresp_data_ok: input, 1 bit, data access complete.
- dresp_data: input, XLEN bits, load data.
REQ-009 The module SHALL have these decode/execute ports:
- dec_mem_rd: input, 1 bit, load.
- dec_mem_wr: input, 1 bit, store.
- dec_multi: input, 1 bit, multi-cycle op.
- dec_rf_we: input, 1 bit, writes register file.
- ex_addr: input, XLEN bits, effective address.
- ex_wdata: input, XLEN bits, store data.
- ex_strobe: input, XLEN/8 bits, store byte mask.
- next_pc: input, XLEN bits, resolved next PC.
REQ-010 The module SHALL have these outputs:
- pc: output, XLEN bits, current instruction PC.
- instr: output, ILEN bits, latched instruction.
- mem_rdata: output, XLEN bits, latched load data.
- rf_we: output, 1 bit, register write pulse.
- commit_valid: output, 1 bit, retire pulse.
- commit_pc: output, XLEN bits, PC of the retired instruction.

Function
REQ-011 The FSM SHALL have states IFETCH, DECODE, EXECUTE, MEM, WB, with state and all outputs registered.
REQ-012 IFETCH SHALL hold ireq_valid=1 and ireq_addr=pc until the first cycle with iresp_data_ok=1; at that edge it SHALL latch instr=iresp_data, drop ireq_valid, and go to DECODE.
REQ-013 An iresp_data_ok arriving in the first cycle ireq_valid is high SHALL be accepted; iresp_data_ok outside IFETCH SHALL be ignored.
REQ-014 DECODE SHALL last exactly 1 cycle, then go to EXECUTE, loading the execute counter with MULTI_LAT-1 if dec_multi=1, else 0.
REQ-015 EXECUTE SHALL decrement the counter each cycle and leave when the counter is 0, going to MEM if dec_mem_rd|dec_mem_wr, else to WB.
REQ-016 Minimum latency SHALL be 4 cycles for ALU ops, with a zero-wait fetch: IFETCH, DECODE, EXECUTE, WB.
REQ-017 MEM SHALL drive these fields and hold them stable until dresp_data_ok:
- dreq_valid=1.
- dreq_addr=ex_addr.
- dreq_data=ex_wdata.
- dreq_strobe=ex_strobe for a store, 0 for a load.
REQ-018 On dresp_data_ok in MEM, the module SHALL latch mem_rdata=dresp_data (loads only), drop dreq_valid, and go to WB.
REQ-019 If dec_mem_rd and dec_mem_wr are both 1, the access SHALL be treated as a load (strobe 0).
REQ-020 WB SHALL pulse commit_valid=1 for exactly 1 cycle, with commit_pc=pc and rf_we=dec_rf_we (rf_we never high outside WB).
REQ-021 WB SHALL update pc<=next_pc and return to IFETCH.
REQ-022 ireq_valid and dreq_valid SHALL never be high in the same cycle.

Reset
REQ-023 When rst=1 at a clock edge, the module SHALL set:
- state=IFETCH, pc=RESET_PC.
- instr=0, mem_rdata=0, counter=0.
- ireq_valid=0, dreq_valid=0, dreq_strobe=0.
- rf_we=0, commit_valid=0, commit_pc=0.
REQ-024 ireq_valid SHALL rise in the first cycle after rst deasserts.
REQ-025 Reset mid-transaction SHALL abandon the in-flight fetch, execute or access without a commit pulse; the bus is reset together with this block.

Configuration
REQ-026 With SEQ_PERF_CNT_EN defined, the module SHALL expose two 64-bit outputs:
- mcycle: increments every non-reset cycle.
- minstret: increments on each commit_valid.
Both SHALL reset to 0 and wrap from all-ones to 0.
REQ-027 Without SEQ_PERF_CNT_EN, neither port nor counter SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Scenario: release reset, iresp_data_ok on the first request cycle, ALU op with next_pc=RESET_PC+4 -> ireq_addr=64'h8000_0000, commit_valid in cycle 4, then ireq_addr=64'h8000_0004.
REQ-029 Scenario: fetch with iresp_data_ok delayed 3 cycles -> ireq_valid high for 4 cycles with ireq_addr constant, instr latched from the 4th-cycle data.
REQ-030 Scenario: load with ex_addr=64'h1000, dresp_data=64'hDEAD_BEEF after 2 wait cycles -> dreq_strobe=0 and stable, mem_rdata=64'hDEAD_BEEF, rf_we pulse in WB.
REQ-031 Scenario: store with ex_strobe=8'h0F, ex_wdata=64'h1234 -> dreq_strobe=8'h0F, dreq_data=64'h1234, commit_valid=1, rf_we=0 when dec_rf_we=0.
REQ-032 Scenario: dec_multi=1 with MULTI_LAT=4 -> EXECUTE lasts 4 cycles, commit in cycle 7 after a zero-wait fetch.
REQ-033 Scenario: rst asserted during a MEM wait with SEQ_PERF_CNT_EN defined -> no commit, dreq_valid=0 after the edge, mcycle=minstret=0, fetch restarts at RESET_PC.
